// File: rtl/z80_pkg.sv
// Shared types and constants for the Z80 bus bridge.
// Holds the bridge FSM state type and the idle bus data value.
package z80_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_MEM    = 3'd1,
    ST_MEM_WS = 3'd2,
    ST_IO     = 3'd3,
    ST_INTA   = 3'd4,
    ST_DONE   = 3'd5
  } bridge_state_t;

  localparam logic [7:0] BUS_IDLE_DATA = 8'hFF;

  // States in which the CPU must be stalled.
  function automatic logic is_busy(bridge_state_t s);
    return (s == ST_MEM) || (s == ST_MEM_WS) ||
           (s == ST_IO)  || (s == ST_INTA);
  endfunction

endpackage

// File: rtl/z80_bus_bridge.sv
// Z80 strobe bus to synchronous RAM / peripheral port bridge.
// Optional IO timeout: define Z80_BRIDGE_TIMEOUT_EN.
import z80_pkg::*;

module z80_bus_bridge #(
  parameter int WAIT_STATES = 0,
  parameter int IO_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr_bus,
  input  logic [7:0]  cpu_dout,
  input  logic        MREQ_L,
  input  logic        IORQ_L,
  input  logic        RD_L,
  input  logic        WR_L,
  input  logic        M1_L,
  output logic [7:0]  cpu_din,
  output logic        WAIT_L,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  output logic        io_rd,
  output logic        io_wr,
  input  logic [7:0]  io_rdata,
  input  logic        io_ack,
  input  logic [7:0]  int_vector,
  output logic        io_timeout_err
);

  localparam logic [7:0] WS_LAST = 8'(WAIT_STATES - 1);
  localparam logic [7:0] TO_LAST = 8'(IO_TIMEOUT - 1);

  bridge_state_t state;
  logic [7:0]    cnt;
  logic          rd_cap;
  logic          rd_req;
  logic          xfer_req;

  // A cycle with both RD_L and WR_L low is a read.
  assign rd_req   = !RD_L;
  assign xfer_req = !RD_L || !WR_L;

  assign WAIT_L = !is_busy(state);

`ifdef Z80_BRIDGE_TIMEOUT_EN
  logic err_q;
  assign io_timeout_err = err_q;
`else
  logic unused_cfg;
  assign unused_cfg     = ^TO_LAST;
  assign io_timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 8'd0;
      rd_cap    <= 1'b0;
      cpu_din   <= BUS_IDLE_DATA;
      mem_addr  <= 16'd0;
      mem_wdata <= 8'd0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      io_addr   <= 8'd0;
      io_wdata  <= 8'd0;
      io_rd     <= 1'b0;
      io_wr     <= 1'b0;
`ifdef Z80_BRIDGE_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      mem_re <= 1'b0;
      mem_we <= 1'b0;
      // RAM data arrives one cycle after the read strobe.
      rd_cap <= mem_re;
      if (rd_cap)
        cpu_din <= mem_rdata;

      unique case (state)
        ST_IDLE: begin
          if (!MREQ_L) begin
            if (xfer_req) begin
              state     <= ST_MEM;
              mem_addr  <= addr_bus;
              mem_wdata <= cpu_dout;
              mem_re    <= rd_req;
              mem_we    <= !rd_req;
            end
          end else if (!IORQ_L) begin
            if (!M1_L) begin
              state   <= ST_INTA;
              cpu_din <= int_vector;
            end else if (xfer_req) begin
              state    <= ST_IO;
              cnt      <= 8'd0;
              io_addr  <= addr_bus[7:0];
              io_wdata <= cpu_dout;
              io_rd    <= rd_req;
              io_wr    <= !rd_req;
            end
          end
        end

        ST_MEM: begin
          if (WAIT_STATES > 0) begin
            state <= ST_MEM_WS;
            cnt   <= WS_LAST;
          end else begin
            state <= ST_DONE;
          end
        end

        ST_MEM_WS: begin
          if (cnt == 8'd0)
            state <= ST_DONE;
          else
            cnt <= cnt - 8'd1;
        end

        ST_IO: begin
          if (io_ack) begin
            if (io_rd)
              cpu_din <= io_rdata;
            io_rd <= 1'b0;
            io_wr <= 1'b0;
            state <= ST_DONE;
          end
`ifdef Z80_BRIDGE_TIMEOUT_EN
          else if (cnt == TO_LAST) begin
            io_rd   <= 1'b0;
            io_wr   <= 1'b0;
            cpu_din <= BUS_IDLE_DATA;
            err_q   <= 1'b1;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + 8'd1;
          end
`endif
        end

        ST_INTA: state <= ST_DONE;

        // Wait for both strobes to drop so a held cycle cannot retrigger.
        ST_DONE: begin
          if (MREQ_L && IORQ_L)
            state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
